// File: rtl/stream_credit_arbiter.sv
// Converge controller: merges freespace updates and credit-gated data packets onto one stream,
// with round-robin fairness and single-packet replay. Optional counters: STREAM_CREDIT_ARB_STATS_EN.
module stream_credit_arbiter #(
  parameter int unsigned PACKET_BITS           = 97,
  parameter int unsigned NUM_IN_PORTS          = 7,
  parameter int unsigned NUM_OUT_PORTS         = 7,
  parameter int unsigned CREDIT_BITS           = 8,
  parameter int unsigned INIT_CREDIT           = 64,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   resend,
  input  logic [NUM_IN_PORTS-1:0]                freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]    packet_from_input_ports,
  input  logic [NUM_OUT_PORTS-1:0]               empty,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   packet_from_output_ports,
  input  logic [NUM_OUT_PORTS-1:0]               credit_return,
  output logic [NUM_OUT_PORTS-1:0]               outport_sel,
  output logic [NUM_IN_PORTS-1:0]                inport_ack,
  output logic [PACKET_BITS-1:0]                 stream_out,
  output logic [NUM_OUT_PORTS-1:0]               credit_stall
`ifdef STREAM_CREDIT_ARB_STATS_EN
  ,
  output logic [32*NUM_OUT_PORTS-1:0]            sent_cnt,
  output logic [31:0]                            stall_cyc_cnt
`endif
);

  localparam int unsigned IPW  = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
  localparam int unsigned OPW  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int unsigned SUMW = CREDIT_BITS + 32;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

  typedef enum logic {RUN, REPLAY} state_e;

  state_e                   state_q, state_d;
  logic [IPW-1:0]           in_ptr_q, in_ptr_d;
  logic [OPW-1:0]           out_ptr_q, out_ptr_d;
  logic [PACKET_BITS-1:0]   replay_q, replay_d;
  logic [PACKET_BITS-1:0]   stream_d;
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [SUMW-1:0]          csum     [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] stall_d;
  logic [NUM_OUT_PORTS-1:0] data_req;
  logic                     do_arb;
  int                       in_pick, out_pick;

  // Returns the first set request at or after ptr (wrapping), or -1; port counts up to 32.
  function automatic int rr_pick(input logic [31:0] req, input int unsigned ptr,
                                 input int unsigned n);
    int          sel;
    int unsigned idx;
    sel = -1;
    for (int unsigned k = 0; k < n; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (sel < 0 && req[idx[4:0]]) sel = int'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NUM_OUT_PORTS; p++) begin
      data_req[p] = !empty[p] && (credit_q[p] != '0);
    end
    in_pick  = rr_pick(32'(freespace_update), 32'(in_ptr_q), NUM_IN_PORTS);
    out_pick = rr_pick(32'(data_req), 32'(out_ptr_q), NUM_OUT_PORTS);
  end

  // Replay is issued in the cycle resend is sampled, so a held resend re-sends every cycle
  // and arbitration resumes in the first cycle resend is low.
  always_comb begin
    state_d     = state_q;
    in_ptr_d    = in_ptr_q;
    out_ptr_d   = out_ptr_q;
    replay_d    = replay_q;
    stream_d    = '0;
    inport_ack  = '0;
    outport_sel = '0;
    do_arb      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (resend) begin
          state_d  = REPLAY;
          stream_d = replay_q;
        end else begin
          do_arb = 1'b1;
        end
      end
      REPLAY: begin
        if (resend) begin
          stream_d = replay_q;
        end else begin
          state_d = RUN;
          do_arb  = 1'b1;
        end
      end
    endcase

    if (do_arb && !reset) begin
      if (in_pick >= 0) begin
        for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
          if (in_pick == int'(i)) begin
            inport_ack[i] = 1'b1;
            stream_d      = packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
            in_ptr_d      = (i == NUM_IN_PORTS - 1) ? '0 : IPW'(i + 1);
          end
        end
        replay_d = stream_d;
      end else if (out_pick >= 0) begin
        for (int unsigned o = 0; o < NUM_OUT_PORTS; o++) begin
          if (out_pick == int'(o)) begin
            outport_sel[o] = 1'b1;
            stream_d       = packet_from_output_ports[o*PACKET_BITS +: PACKET_BITS];
            out_ptr_d      = (o == NUM_OUT_PORTS - 1) ? '0 : OPW'(o + 1);
          end
        end
        replay_d = stream_d;
      end
    end
  end

  // A granted port always holds credit >= 1, so the subtraction cannot underflow.
  always_comb begin
    for (int unsigned p = 0; p < NUM_OUT_PORTS; p++) begin
      csum[p] = SUMW'(credit_q[p])
              + (credit_return[p] ? SUMW'(FREESPACE_UPDATE_SIZE) : SUMW'(0))
              - (outport_sel[p]   ? SUMW'(1) : SUMW'(0));
      credit_d[p] = (csum[p] > SUMW'(CREDIT_MAX)) ? CREDIT_MAX : csum[p][CREDIT_BITS-1:0];
      stall_d[p]  = !empty[p] && (credit_q[p] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      in_ptr_q     <= '0;
      out_ptr_q    <= '0;
      replay_q     <= '0;
      stream_out   <= '0;
      credit_stall <= '0;
      for (int unsigned p = 0; p < NUM_OUT_PORTS; p++) begin
        credit_q[p] <= CREDIT_BITS'(INIT_CREDIT);
      end
    end else begin
      state_q      <= state_d;
      in_ptr_q     <= in_ptr_d;
      out_ptr_q    <= out_ptr_d;
      replay_q     <= replay_d;
      stream_out   <= stream_d;
      credit_stall <= stall_d;
      for (int unsigned p = 0; p < NUM_OUT_PORTS; p++) begin
        credit_q[p] <= credit_d[p];
      end
    end
  end

`ifdef STREAM_CREDIT_ARB_STATS_EN
  logic [31:0] sent_q [NUM_OUT_PORTS];
  logic [31:0] stall_cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q <= '0;
      for (int unsigned p = 0; p < NUM_OUT_PORTS; p++) begin
        sent_q[p] <= '0;
      end
    end else begin
      if (|credit_stall) stall_cyc_q <= stall_cyc_q + 32'd1;
      for (int unsigned p = 0; p < NUM_OUT_PORTS; p++) begin
        if (outport_sel[p]) sent_q[p] <= sent_q[p] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_sent
    assign sent_cnt[g*32 +: 32] = sent_q[g];
  end
  assign stall_cyc_cnt = stall_cyc_q;
`endif

endmodule

// File: tb/tb_stream_credit_arbiter.sv
// Scoreboard bench for stream_credit_arbiter: a queue-and-array reference model predicts grants,
// credits and packets; a separate monitor checks stream_out against the expected queue.
module tb_stream_credit_arbiter;
  localparam int PB = 97;
  localparam int NI = 7;
  localparam int NO = 7;
  localparam int INIT = 3;
  localparam int FSU = 64;
  localparam int CMAX = 255;

  logic              clk, reset, resend;
  logic [NI-1:0]     freespace_update;
  logic [PB*NI-1:0]  packet_from_input_ports;
  logic [NO-1:0]     empty;
  logic [PB*NO-1:0]  packet_from_output_ports;
  logic [NO-1:0]     credit_return;
  logic [NO-1:0]     outport_sel;
  logic [NI-1:0]     inport_ack;
  logic [PB-1:0]     stream_out;
  logic [NO-1:0]     credit_stall;
`ifdef STREAM_CREDIT_ARB_STATS_EN
  logic [32*NO-1:0]  sent_cnt;
  logic [31:0]       stall_cyc_cnt;
`endif

  stream_credit_arbiter #(
    .PACKET_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .CREDIT_BITS(8),
    .INIT_CREDIT(INIT), .FREESPACE_UPDATE_SIZE(FSU)
  ) dut (
    .clk(clk), .reset(reset), .resend(resend), .freespace_update(freespace_update),
    .packet_from_input_ports(packet_from_input_ports), .empty(empty),
    .packet_from_output_ports(packet_from_output_ports), .credit_return(credit_return),
    .outport_sel(outport_sel), .inport_ack(inport_ack), .stream_out(stream_out),
    .credit_stall(credit_stall)
`ifdef STREAM_CREDIT_ARB_STATS_EN
    , .sent_cnt(sent_cnt), .stall_cyc_cnt(stall_cyc_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int            cyc;
    logic [PB-1:0] pkt;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  // reference model state
  int            credit[NO];
  int            iptr, optr;
  logic [PB-1:0] replay_pkt;
  logic [NI-1:0] fs_req;
  logic [NO-1:0] exp_stall;
  bit            stall_chk;
  int            sent_m[NO];
  int            stall_cnt_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [PB-1:0] rand_pkt();
    logic [127:0] r;
    logic [PB-1:0] p;
    r = {$urandom, $urandom, $urandom, $urandom};
    p = r[PB-1:0];
    p[PB-1] = 1'b1;
    return p;
  endfunction

  // Applies one cycle of stimulus at posedge+1, predicts the response, then advances to the next posedge+1.
  task automatic step(input logic rst, input logic rs, input logic [NI-1:0] fs_new,
                      input logic [NO-1:0] emp, input logic [NO-1:0] ret);
    logic [PB-1:0] ipk[NI];
    logic [PB-1:0] opk[NO];
    logic [NO-1:0] exp_sel;
    logic [NI-1:0] exp_ack;
    logic [NO-1:0] prev_stall;
    int g, idx;
    exp_t e;

    if (stall_chk) chk("credit_stall", 128'(credit_stall), 128'(exp_stall));
    prev_stall = exp_stall;

    fs_req = fs_req | fs_new;
    reset = rst;
    resend = rs;
    freespace_update = fs_req;
    empty = emp;
    credit_return = ret;
    for (int i = 0; i < NI; i++) begin
      ipk[i] = rand_pkt();
      packet_from_input_ports[i*PB +: PB] = ipk[i];
    end
    for (int o = 0; o < NO; o++) begin
      opk[o] = rand_pkt();
      packet_from_output_ports[o*PB +: PB] = opk[o];
    end
    #1;

    exp_sel = '0;
    exp_ack = '0;
    for (int p = 0; p < NO; p++) exp_stall[p] = !emp[p] && (credit[p] == 0);

    if (rst) begin
      for (int p = 0; p < NO; p++) begin
        credit[p] = INIT;
        sent_m[p] = 0;
      end
      iptr = 0;
      optr = 0;
      replay_pkt = '0;
      exp_stall = '0;
      stall_cnt_m = 0;
    end else begin
      if (prev_stall != '0) stall_cnt_m++;
      if (rs) begin
        if (replay_pkt[PB-1]) begin
          e.cyc = cyc + 1;
          e.pkt = replay_pkt;
          sbq.push_back(e);
        end
      end else begin
        g = -1;
        for (int k = 0; k < NI; k++) begin
          idx = (iptr + k) % NI;
          if (g < 0 && fs_req[idx]) g = idx;
        end
        if (g >= 0) begin
          exp_ack[g] = 1'b1;
          fs_req[g] = 1'b0;
          iptr = (g + 1) % NI;
          replay_pkt = ipk[g];
        end else begin
          for (int k = 0; k < NO; k++) begin
            idx = (optr + k) % NO;
            if (g < 0 && !emp[idx] && credit[idx] > 0) g = idx;
          end
          if (g >= 0) begin
            exp_sel[g] = 1'b1;
            credit[g] = credit[g] - 1;
            sent_m[g]++;
            optr = (g + 1) % NO;
            replay_pkt = opk[g];
          end
        end
        if (g >= 0) begin
          e.cyc = cyc + 1;
          e.pkt = replay_pkt;
          sbq.push_back(e);
        end
      end
      for (int p = 0; p < NO; p++) begin
        if (ret[p]) credit[p] = (credit[p] + FSU > CMAX) ? CMAX : credit[p] + FSU;
      end
    end

    chk("outport_sel", 128'(outport_sel), 128'(exp_sel));
    chk("inport_ack", 128'(inport_ack), 128'(exp_ack));
    stall_chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // monitor: every valid packet on stream_out must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (stream_out[PB-1] === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream_out_unexpected at cycle %0d: got %h expected no packet", cyc, stream_out);
        end else begin
          e = sbq.pop_front();
          chk("stream_out_cycle", 128'(cyc), 128'(e.cyc));
          chk("stream_out_pkt", 128'(stream_out), 128'(e.pkt));
        end
      end else begin
        chk("stream_out_idle", 128'(stream_out), 128'(0));
      end
    end
  end

  localparam logic [NO-1:0] ALL_EMPTY = '1;

  initial begin
    reset = 1'b1;
    resend = 1'b0;
    freespace_update = '0;
    empty = '1;
    credit_return = '0;
    packet_from_input_ports = '0;
    packet_from_output_ports = '0;
    fs_req = '0;
    exp_stall = '0;
    stall_chk = 1'b0;
    stall_cnt_m = 0;
    replay_pkt = '0;
    iptr = 0;
    optr = 0;
    for (int p = 0; p < NO; p++) begin
      credit[p] = INIT;
      sent_m[p] = 0;
    end
    @(posedge clk);
    #1;

    step(1, 0, '0, ALL_EMPTY, '0);
    step(1, 0, '0, ALL_EMPTY, '0);
    chk("reset_stream_out", 128'(stream_out), 128'(0));

    // ports 0 and 2 pending: alternating grants until credit runs out
    repeat (8) step(0, 0, '0, ~7'b0000101, '0);
    // freespace updates take priority over pending data
    step(0, 0, '0, ALL_EMPTY, 7'b0000101);
    step(0, 0, 7'b0000101, ~7'b0000101, '0);
    repeat (4) step(0, 0, '0, ~7'b0000101, '0);

    // single requester drains its credit, stalls, then a return restores it
    step(1, 0, '0, ALL_EMPTY, '0);
    repeat (5) step(0, 0, '0, ~7'b0000010, '0);
    step(0, 0, '0, ~7'b0000010, 7'b0000010);
    repeat (4) step(0, 0, '0, ~7'b0000010, '0);

    // same-cycle grant and return on port 4, then saturation at 255
    step(1, 0, '0, ALL_EMPTY, '0);
    step(0, 0, '0, ~7'b0010000, 7'b0010000);
    repeat (5) step(0, 0, '0, ALL_EMPTY, 7'b0010000);
    repeat (258) step(0, 0, '0, ~7'b0010000, '0);

    // replay: one packet, resend held two cycles, then arbitration resumes
    step(1, 0, '0, ALL_EMPTY, '0);
    step(0, 0, '0, ~7'b0000001, '0);
    step(0, 1, '0, ~7'b0001000, '0);
    step(0, 1, '0, ~7'b0001000, '0);
    step(0, 0, '0, ~7'b0001000, '0);

    // reset during replay discards it
    step(0, 1, '0, ALL_EMPTY, '0);
    step(1, 1, '0, ~7'b0000001, '0);
    chk("reset_in_replay_out", 128'(stream_out), 128'(0));
    step(0, 1, '0, ALL_EMPTY, '0);
    repeat (3) step(0, 0, '0, ~7'b0000001, '0);

    for (int n = 0; n < 2000; n++) begin
      logic [NI-1:0] fsn;
      logic [NO-1:0] emp, ret;
      fsn = '0;
      if ($urandom_range(0, 5) == 0) fsn[$urandom_range(0, NI-1)] = 1'b1;
      emp = NO'($urandom) | NO'($urandom);
      ret = '0;
      for (int p = 0; p < NO; p++) ret[p] = ($urandom_range(0, 19) == 0);
      step(0, $urandom_range(0, 9) == 0, fsn, emp, ret);
    end

    repeat (3) step(0, 0, '0, ALL_EMPTY, '0);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

`ifdef STREAM_CREDIT_ARB_STATS_EN
    for (int p = 0; p < NO; p++) chk("sent_cnt", 128'(sent_cnt[p*32 +: 32]), 128'(sent_m[p]));
    chk("stall_cyc_cnt", 128'(stall_cyc_cnt), 128'(stall_cnt_m));
    step(1, 0, '0, ALL_EMPTY, '0);
    chk("sent_cnt_reset", 128'(sent_cnt), 128'(0));
    chk("stall_cyc_cnt_reset", 128'(stall_cyc_cnt), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
